// File: rtl/chia8bit_seq.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock,
// with a start/busy/done handshake. Companion (inverse) of the 4x4 array multiplier.
module chia8bit_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = $clog2(DW);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] step;
  logic [DW-1:0] work;
  logic [VW-1:0] dvs;
  logic [VW-1:0] part;

  logic [VW:0]   shifted;
  logic          fits;
  logic [VW-1:0] part_next;

  // work shifts dividend bits out the top while quotient bits enter at the bottom.
  // The partial remainder is always below the divisor, so VW bits suffice between steps.
  always_comb begin
    shifted   = {part, work[DW-1]};
    fits      = (shifted >= {1'b0, dvs});
    part_next = fits ? (shifted[VW-1:0] - dvs) : shifted[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      work      <= '0;
      dvs       <= '0;
      part      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work <= dividend;
            dvs  <= divisor;
            part <= '0;
            step <= '0;
            if (divisor != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              dz    <= 1'b0;
            end else begin
              done      <= 1'b1;
              dz        <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
            end
          end
        end
        RUN: begin
          work <= {work[DW-2:0], fits};
          part <= part_next;
          step <= step + CW'(1);
          if (step == CW'(DW - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            dz        <= 1'b0;
            quotient  <= {work[DW-2:0], fits};
            remainder <= part_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chia8bit_seq.sv
// Self-checking bench for chia8bit_seq: directed cases, multiplier round trip, handshake,
// mid-operation reset and randomized divides against an arithmetic reference.
module tb_chia8bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic       dz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad   = 0;
  logic [7:0] held_q = 8'h00;

  chia8bit_seq #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .dz(dz), .quotient(quotient), .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Waits for done starting just after an accept edge; returns clocks elapsed, 99 on timeout.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      if (cycles == 4) checkOutput("held_q", {24'b0, quotient}, {24'b0, held_q});
      @(posedge clk); #1;
      cycles++;
    end
    if (!done) cycles = 99;
  endtask

  // Launches one divide and checks the result against plain arithmetic.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
    int cycles;
    int exp_q, exp_r, exp_lat;
    logic exp_dz;
    if (b == 0) begin
      exp_q = 255; exp_r = a % 16; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = 8;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    waitDone(cycles);
    checkOutput("latency", cycles, exp_lat);
    checkOutput("quotient", {24'b0, quotient}, exp_q);
    checkOutput("remainder", {28'b0, remainder}, exp_r);
    checkOutput("dz", {31'b0, dz}, {31'b0, exp_dz});
    held_q = 8'(exp_q);
  endtask

  initial begin
    int cycles;
    int dones;
    rst_n = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    checkOutput("rst_dz", {31'b0, dz}, 0);
    checkOutput("rst_q", {24'b0, quotient}, 0);
    checkOutput("rst_r", {28'b0, remainder}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed divides");
    applyStimulus(8'h6E, 4'hA);
    applyStimulus(8'd200, 4'd7);
    applyStimulus(8'd255, 4'd1);
    applyStimulus(8'd0, 4'd5);
    applyStimulus(8'd100, 4'd0);
    applyStimulus(8'd13, 4'd15);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", {31'b0, done}, 0);

    $display("[TB] multiplier round trip");
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        applyStimulus(8'(a * b), 4'(b));
      end
    end

    $display("[TB] handshake with start held");
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd255; divisor = 4'd15;
    @(posedge clk); #1;
    dividend = 8'd9; divisor = 4'd2;
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("hs_done_count", dones, 1);
    checkOutput("hs_done_last", {31'b0, done}, 1);
    checkOutput("hs_q1", {24'b0, quotient}, 17);
    checkOutput("hs_r1", {28'b0, remainder}, 0);
    held_q = 8'd17;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("hs_busy2", {31'b0, busy}, 1);
    checkOutput("hs_done_drop", {31'b0, done}, 0);
    waitDone(cycles);
    checkOutput("hs_latency2", cycles, 8);
    checkOutput("hs_q2", {24'b0, quotient}, 4);
    checkOutput("hs_r2", {28'b0, remainder}, 1);
    held_q = 8'd4;

    $display("[TB] reset mid-operation");
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", {31'b0, busy}, 0);
    checkOutput("mid_done", {31'b0, done}, 0);
    checkOutput("mid_dz", {31'b0, dz}, 0);
    checkOutput("mid_q", {24'b0, quotient}, 0);
    checkOutput("mid_r", {28'b0, remainder}, 0);
    held_q = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("mid_no_done", dones, 0);
    applyStimulus(8'd50, 4'd6);

    $display("[TB] randomized divides");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
